// File: rtl/alu_rs.sv
// Reservation station in front of the integer ALU. It buffers micro-ops until both
// operands are captured from the CDB, then issues the lowest ready entry each cycle.
module alu_rs #(
   parameter int RS_BITS  = 3,
   parameter int ROB_BITS = 4
) (
   input  logic                clk_in,
   input  logic                rst_in,
   input  logic                clear_in,
   input  logic                dsp_valid,
   input  logic [10:0]         dsp_op,
   input  logic                dsp_q1_busy,
   input  logic                dsp_q2_busy,
   input  logic [ROB_BITS-1:0] dsp_q1,
   input  logic [ROB_BITS-1:0] dsp_q2,
   input  logic [31:0]         dsp_v1,
   input  logic [31:0]         dsp_v2,
   input  logic [31:0]         dsp_pc,
   input  logic [31:0]         dsp_imm,
   input  logic                dsp_is_short,
   input  logic [ROB_BITS-1:0] dsp_rob_id,
   input  logic                cdb0_valid,
   input  logic [ROB_BITS-1:0] cdb0_rob_id,
   input  logic [31:0]         cdb0_value,
   input  logic                cdb1_valid,
   input  logic [ROB_BITS-1:0] cdb1_rob_id,
   input  logic [31:0]         cdb1_value,
   output logic                full,
   output logic                yes,
   output logic [10:0]         op,
   output logic [31:0]         v1,
   output logic [31:0]         v2,
   output logic [31:0]         pc,
   output logic                is_short,
   output logic [31:0]         imm,
   output logic [ROB_BITS-1:0] rob_id
);

   localparam int ENTRIES = 1 << RS_BITS;

   logic [ENTRIES-1:0]  busy_r;
   logic [ENTRIES-1:0]  q1_busy_r;
   logic [ENTRIES-1:0]  q2_busy_r;
   logic [10:0]         op_r       [ENTRIES];
   logic [31:0]         pc_r       [ENTRIES];
   logic [31:0]         imm_r      [ENTRIES];
   logic [ENTRIES-1:0]  is_short_r;
   logic [ROB_BITS-1:0] rob_id_r   [ENTRIES];
   logic [ROB_BITS-1:0] q1_r       [ENTRIES];
   logic [ROB_BITS-1:0] q2_r       [ENTRIES];
   logic [31:0]         v1_r       [ENTRIES];
   logic [31:0]         v2_r       [ENTRIES];

   logic [ENTRIES-1:0]  ready_s;
   logic                sel_found_s;
   logic                dsp_accept_s;
   logic [RS_BITS-1:0]  free_idx_s;
   logic [RS_BITS-1:0]  sel_idx_s;
   logic                dsp_q1_busy_s;
   logic                dsp_q2_busy_s;
   logic [31:0]         dsp_v1_s;
   logic [31:0]         dsp_v2_s;

   function automatic logic [RS_BITS-1:0] lowest_set(input logic [ENTRIES-1:0] vec);
      logic [RS_BITS-1:0] idx;
      idx = {RS_BITS{1'b0}};
      for (int i = ENTRIES - 1; i >= 0; i--) begin
         if (vec[i]) idx = RS_BITS'(i);
         else        idx = idx;
      end
      return idx;
   endfunction

   // Returns {still_pending, value}; port 0 wins if both ports carry the tag.
   function automatic logic [32:0] capture(
      input logic                pending,
      input logic [ROB_BITS-1:0] tag,
      input logic [31:0]         value,
      input logic                c0_valid,
      input logic [ROB_BITS-1:0] c0_tag,
      input logic [31:0]         c0_value,
      input logic                c1_valid,
      input logic [ROB_BITS-1:0] c1_tag,
      input logic [31:0]         c1_value
   );
      logic [32:0] res;
      if (pending && c0_valid && (c0_tag == tag))      res = {1'b0, c0_value};
      else if (pending && c1_valid && (c1_tag == tag)) res = {1'b0, c1_value};
      else                                             res = {pending, value};
      return res;
   endfunction

   assign ready_s      = busy_r & ~q1_busy_r & ~q2_busy_r;
   assign full         = &busy_r;
   assign sel_found_s  = |ready_s;
   assign dsp_accept_s = dsp_valid & ~full;
   assign free_idx_s   = lowest_set(~busy_r);
   assign sel_idx_s    = lowest_set(ready_s);

   // Dispatch-time forwarding of operands broadcast in the same cycle.
   always_comb begin
      {dsp_q1_busy_s, dsp_v1_s} = capture(dsp_q1_busy, dsp_q1, dsp_v1,
                                          cdb0_valid, cdb0_rob_id, cdb0_value,
                                          cdb1_valid, cdb1_rob_id, cdb1_value);
      {dsp_q2_busy_s, dsp_v2_s} = capture(dsp_q2_busy, dsp_q2, dsp_v2,
                                          cdb0_valid, cdb0_rob_id, cdb0_value,
                                          cdb1_valid, cdb1_rob_id, cdb1_value);
   end

   // Entry storage: CDB snoop, issue of the lowest ready entry, dispatch into the lowest free one.
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         busy_r     <= {ENTRIES{1'b0}};
         q1_busy_r  <= {ENTRIES{1'b0}};
         q2_busy_r  <= {ENTRIES{1'b0}};
         is_short_r <= {ENTRIES{1'b0}};
         for (int i = 0; i < ENTRIES; i++) begin
            op_r[i]     <= 11'd0;
            pc_r[i]     <= 32'd0;
            imm_r[i]    <= 32'd0;
            rob_id_r[i] <= {ROB_BITS{1'b0}};
            q1_r[i]     <= {ROB_BITS{1'b0}};
            q2_r[i]     <= {ROB_BITS{1'b0}};
            v1_r[i]     <= 32'd0;
            v2_r[i]     <= 32'd0;
         end
         yes      <= 1'b0;
         op       <= 11'd0;
         v1       <= 32'd0;
         v2       <= 32'd0;
         pc       <= 32'd0;
         is_short <= 1'b0;
         imm      <= 32'd0;
         rob_id   <= {ROB_BITS{1'b0}};
      end else if (clear_in) begin
         busy_r <= {ENTRIES{1'b0}};
         yes    <= 1'b0;
      end else begin
         for (int i = 0; i < ENTRIES; i++) begin
            if (busy_r[i]) begin
               {q1_busy_r[i], v1_r[i]} <= capture(q1_busy_r[i], q1_r[i], v1_r[i],
                                                  cdb0_valid, cdb0_rob_id, cdb0_value,
                                                  cdb1_valid, cdb1_rob_id, cdb1_value);
               {q2_busy_r[i], v2_r[i]} <= capture(q2_busy_r[i], q2_r[i], v2_r[i],
                                                  cdb0_valid, cdb0_rob_id, cdb0_value,
                                                  cdb1_valid, cdb1_rob_id, cdb1_value);
            end
         end
         if (sel_found_s) begin
            busy_r[sel_idx_s] <= 1'b0;
            yes      <= 1'b1;
            op       <= op_r[sel_idx_s];
            v1       <= v1_r[sel_idx_s];
            v2       <= v2_r[sel_idx_s];
            pc       <= pc_r[sel_idx_s];
            is_short <= is_short_r[sel_idx_s];
            imm      <= imm_r[sel_idx_s];
            rob_id   <= rob_id_r[sel_idx_s];
         end else begin
            yes <= 1'b0;
         end
         // The free slot is never the issuing one, so both writes can land on one edge.
         if (dsp_accept_s) begin
            busy_r[free_idx_s]     <= 1'b1;
            op_r[free_idx_s]       <= dsp_op;
            pc_r[free_idx_s]       <= dsp_pc;
            imm_r[free_idx_s]      <= dsp_imm;
            is_short_r[free_idx_s] <= dsp_is_short;
            rob_id_r[free_idx_s]   <= dsp_rob_id;
            q1_busy_r[free_idx_s]  <= dsp_q1_busy_s;
            q1_r[free_idx_s]       <= dsp_q1;
            v1_r[free_idx_s]       <= dsp_v1_s;
            q2_busy_r[free_idx_s]  <= dsp_q2_busy_s;
            q2_r[free_idx_s]       <= dsp_q2;
            v2_r[free_idx_s]       <= dsp_v2_s;
         end
      end
   end

endmodule

// File: tb/tb_alu_rs.sv
// Self-checking bench for alu_rs: directed scenarios plus a randomized run against
// a transaction-level model of the station.
module tb_alu_rs;

   logic        clk_in, rst_in, clear_in;
   logic        dsp_valid;
   logic [10:0] dsp_op;
   logic        dsp_q1_busy, dsp_q2_busy;
   logic [3:0]  dsp_q1, dsp_q2;
   logic [31:0] dsp_v1, dsp_v2, dsp_pc, dsp_imm;
   logic        dsp_is_short;
   logic [3:0]  dsp_rob_id;
   logic        cdb0_valid, cdb1_valid;
   logic [3:0]  cdb0_rob_id, cdb1_rob_id;
   logic [31:0] cdb0_value, cdb1_value;
   logic        full, yes, is_short;
   logic [10:0] op;
   logic [31:0] v1, v2, pc, imm;
   logic [3:0]  rob_id;

   int checks = 0;
   int errors = 0;

   alu_rs #(.RS_BITS(3), .ROB_BITS(4)) dut (
      .clk_in(clk_in), .rst_in(rst_in), .clear_in(clear_in),
      .dsp_valid(dsp_valid), .dsp_op(dsp_op),
      .dsp_q1_busy(dsp_q1_busy), .dsp_q2_busy(dsp_q2_busy),
      .dsp_q1(dsp_q1), .dsp_q2(dsp_q2), .dsp_v1(dsp_v1), .dsp_v2(dsp_v2),
      .dsp_pc(dsp_pc), .dsp_imm(dsp_imm), .dsp_is_short(dsp_is_short), .dsp_rob_id(dsp_rob_id),
      .cdb0_valid(cdb0_valid), .cdb0_rob_id(cdb0_rob_id), .cdb0_value(cdb0_value),
      .cdb1_valid(cdb1_valid), .cdb1_rob_id(cdb1_rob_id), .cdb1_value(cdb1_value),
      .full(full), .yes(yes), .op(op), .v1(v1), .v2(v2), .pc(pc),
      .is_short(is_short), .imm(imm), .rob_id(rob_id)
   );

   initial clk_in = 1'b0;
   always #5 clk_in = ~clk_in;

   // Reference model: a table of waiting instructions plus the last issued payload.
   typedef struct {
      bit          busy;
      logic [10:0] op;
      logic [31:0] pc, imm;
      bit          sh;
      logic [3:0]  rob;
      bit          q1b;
      logic [3:0]  q1;
      logic [31:0] v1;
      bit          q2b;
      logic [3:0]  q2;
      logic [31:0] v2;
   } ent_t;

   ent_t        m_ent [8];
   bit          m_yes;
   logic [10:0] m_op;
   logic [31:0] m_v1, m_v2, m_pc, m_imm;
   bit          m_sh;
   logic [3:0]  m_rob;

   task automatic model_reset();
      for (int i = 0; i < 8; i++) begin
         m_ent[i].busy = 1'b0; m_ent[i].q1b = 1'b0; m_ent[i].q2b = 1'b0;
      end
      m_yes = 1'b0; m_op = 11'd0; m_v1 = 32'd0; m_v2 = 32'd0;
      m_pc = 32'd0; m_imm = 32'd0; m_sh = 1'b0; m_rob = 4'd0;
   endtask

   function automatic bit m_full();
      int n = 0;
      for (int i = 0; i < 8; i++) if (m_ent[i].busy) n++;
      return (n == 8);
   endfunction

   function automatic void cdb_lookup(input logic [3:0] tag, output bit hit, output logic [31:0] val);
      hit = 1'b0; val = 32'd0;
      if (cdb0_valid && cdb0_rob_id == tag) begin hit = 1'b1; val = cdb0_value; end
      else if (cdb1_valid && cdb1_rob_id == tag) begin hit = 1'b1; val = cdb1_value; end
   endfunction

   task automatic model_step();
      ent_t        nxt [8];
      int          sel, fr;
      bit          hit;
      logic [31:0] val;
      if (clear_in) begin
         for (int i = 0; i < 8; i++) m_ent[i].busy = 1'b0;
         m_yes = 1'b0;
      end else begin
         sel = -1; fr = -1;
         for (int i = 0; i < 8; i++) begin
            if (sel < 0 && m_ent[i].busy && !m_ent[i].q1b && !m_ent[i].q2b) sel = i;
            if (fr < 0 && !m_ent[i].busy) fr = i;
            nxt[i] = m_ent[i];
         end
         for (int i = 0; i < 8; i++) begin
            if (nxt[i].busy && nxt[i].q1b) begin
               cdb_lookup(nxt[i].q1, hit, val);
               if (hit) begin nxt[i].q1b = 1'b0; nxt[i].v1 = val; end
            end
            if (nxt[i].busy && nxt[i].q2b) begin
               cdb_lookup(nxt[i].q2, hit, val);
               if (hit) begin nxt[i].q2b = 1'b0; nxt[i].v2 = val; end
            end
         end
         if (sel >= 0) begin
            m_yes = 1'b1; m_op = m_ent[sel].op; m_v1 = m_ent[sel].v1; m_v2 = m_ent[sel].v2;
            m_pc = m_ent[sel].pc; m_imm = m_ent[sel].imm; m_sh = m_ent[sel].sh; m_rob = m_ent[sel].rob;
            nxt[sel].busy = 1'b0;
         end else begin
            m_yes = 1'b0;
         end
         if (dsp_valid && fr >= 0) begin
            nxt[fr].busy = 1'b1; nxt[fr].op = dsp_op; nxt[fr].pc = dsp_pc; nxt[fr].imm = dsp_imm;
            nxt[fr].sh = dsp_is_short; nxt[fr].rob = dsp_rob_id;
            nxt[fr].q1b = dsp_q1_busy; nxt[fr].q1 = dsp_q1; nxt[fr].v1 = dsp_v1;
            nxt[fr].q2b = dsp_q2_busy; nxt[fr].q2 = dsp_q2; nxt[fr].v2 = dsp_v2;
            if (dsp_q1_busy) begin
               cdb_lookup(dsp_q1, hit, val);
               if (hit) begin nxt[fr].q1b = 1'b0; nxt[fr].v1 = val; end
            end
            if (dsp_q2_busy) begin
               cdb_lookup(dsp_q2, hit, val);
               if (hit) begin nxt[fr].q2b = 1'b0; nxt[fr].v2 = val; end
            end
         end
         for (int i = 0; i < 8; i++) m_ent[i] = nxt[i];
      end
   endtask

   task automatic tick();
      model_step();
      @(posedge clk_in);
      #1;
   endtask

   task automatic idle();
      dsp_valid = 1'b0; dsp_op = 11'd0; dsp_q1_busy = 1'b0; dsp_q2_busy = 1'b0;
      dsp_q1 = 4'd0; dsp_q2 = 4'd0; dsp_v1 = 32'd0; dsp_v2 = 32'd0;
      dsp_pc = 32'd0; dsp_imm = 32'd0; dsp_is_short = 1'b0; dsp_rob_id = 4'd0;
      cdb0_valid = 1'b0; cdb0_rob_id = 4'd0; cdb0_value = 32'd0;
      cdb1_valid = 1'b0; cdb1_rob_id = 4'd0; cdb1_value = 32'd0;
      clear_in = 1'b0;
   endtask

   task automatic set_dsp(input logic [10:0] o, input logic q1b, input logic [3:0] q1, input logic [31:0] a,
                          input logic q2b, input logic [3:0] q2, input logic [31:0] b, input logic [3:0] rob);
      dsp_valid = 1'b1; dsp_op = o;
      dsp_q1_busy = q1b; dsp_q1 = q1; dsp_v1 = a;
      dsp_q2_busy = q2b; dsp_q2 = q2; dsp_v2 = b;
      dsp_rob_id = rob; dsp_pc = {28'h0000100, rob}; dsp_imm = {28'hABC0000, rob}; dsp_is_short = rob[0];
   endtask

   task automatic do_reset();
      idle();
      rst_in = 1'b1;
      model_reset();
      @(posedge clk_in);
      #1;
      rst_in = 1'b0;
   endtask

   task automatic test_reset();
      #1;
      checks++; if (yes !== 1'b0) begin errors++; $display("FAIL reset_yes: got %0b expected 0", yes); end
      checks++; if (full !== 1'b0) begin errors++; $display("FAIL reset_full: got %0b expected 0", full); end
      checks++; if ({op, v1, v2, pc, imm, is_short, rob_id} !== 144'd0) begin
         errors++; $display("FAIL reset_payload: got %h expected 0", {op, v1, v2, pc, imm, is_short, rob_id}); end
      do_reset();
      checks++; if (yes !== 1'b0 || full !== 1'b0) begin
         errors++; $display("FAIL reset_release: got yes=%0b full=%0b expected 0/0", yes, full); end
   endtask

   task automatic test_ready_dispatch();
      do_reset();
      set_dsp(11'h033, 1'b0, 4'd0, 32'd5, 1'b0, 4'd0, 32'd7, 4'd3);
      tick(); idle();
      checks++; if (yes !== 1'b0) begin errors++; $display("FAIL ready_early: got %0b expected 0", yes); end
      tick();
      checks++; if (yes !== 1'b1) begin errors++; $display("FAIL ready_yes: got %0b expected 1", yes); end
      checks++; if ({op, v1, v2, rob_id, pc} !== {11'h033, 32'd5, 32'd7, 4'd3, 32'h0000_1003}) begin
         errors++; $display("FAIL ready_payload: got %h expected %h", {op, v1, v2, rob_id, pc},
                            {11'h033, 32'd5, 32'd7, 4'd3, 32'h0000_1003}); end
      tick();
      checks++; if (yes !== 1'b0 || v1 !== 32'd5) begin
         errors++; $display("FAIL ready_pulse: got yes=%0b v1=%0h expected 0/5", yes, v1); end
   endtask

   task automatic test_pending();
      do_reset();
      set_dsp(11'h033, 1'b1, 4'd6, 32'd0, 1'b0, 4'd0, 32'd1, 4'd5);
      tick(); idle();
      for (int k = 0; k < 3; k++) begin
         tick();
         checks++; if (yes !== 1'b0) begin errors++; $display("FAIL pend_wait%0d: got %0b expected 0", k, yes); end
      end
      cdb1_valid = 1'b1; cdb1_rob_id = 4'd6; cdb1_value = 32'h10;
      tick(); idle();
      checks++; if (yes !== 1'b0) begin errors++; $display("FAIL pend_capture_edge: got %0b expected 0", yes); end
      tick();
      checks++; if (yes !== 1'b1 || v1 !== 32'h10 || v2 !== 32'd1 || rob_id !== 4'd5) begin
         errors++; $display("FAIL pend_issue: got yes=%0b v1=%0h v2=%0h rob=%0d expected 1/10/1/5", yes, v1, v2, rob_id); end
   endtask

   task automatic test_forward();
      do_reset();
      set_dsp(11'h433, 1'b0, 4'd0, 32'd4, 1'b1, 4'd2, 32'd0, 4'd7);
      cdb0_valid = 1'b1; cdb0_rob_id = 4'd2; cdb0_value = 32'd9;
      tick(); idle();
      checks++; if (yes !== 1'b0) begin errors++; $display("FAIL fwd_early: got %0b expected 0", yes); end
      tick();
      checks++; if (yes !== 1'b1 || v2 !== 32'd9 || v1 !== 32'd4 || op !== 11'h433) begin
         errors++; $display("FAIL fwd_issue: got yes=%0b v1=%0h v2=%0h op=%0h expected 1/4/9/433", yes, v1, v2, op); end
   endtask

   task automatic test_fill_priority();
      do_reset();
      for (int k = 0; k < 8; k++) begin
         set_dsp(11'h033, 1'b1, 4'd9, 32'd0, 1'b0, 4'd0, 32'(k + 100), 4'(k));
         tick(); idle();
      end
      checks++; if (full !== 1'b1 || yes !== 1'b0) begin
         errors++; $display("FAIL fill_full: got full=%0b yes=%0b expected 1/0", full, yes); end
      set_dsp(11'h033, 1'b0, 4'd0, 32'd1, 1'b0, 4'd0, 32'd2, 4'd15);
      tick(); idle();
      checks++; if (full !== 1'b1 || yes !== 1'b0) begin
         errors++; $display("FAIL fill_drop: got full=%0b yes=%0b expected 1/0", full, yes); end
      cdb0_valid = 1'b1; cdb0_rob_id = 4'd9; cdb0_value = 32'h77;
      tick(); idle();
      checks++; if (yes !== 1'b0) begin errors++; $display("FAIL fill_release_edge: got %0b expected 0", yes); end
      for (int k = 0; k < 8; k++) begin
         if (k == 0) set_dsp(11'h033, 1'b0, 4'd0, 32'd1, 1'b0, 4'd0, 32'd2, 4'd14);
         tick(); idle();
         checks++; if (yes !== 1'b1 || rob_id !== 4'(k) || v1 !== 32'h77 || v2 !== 32'(k + 100)) begin
            errors++; $display("FAIL fill_order%0d: got yes=%0b rob=%0d v1=%0h v2=%0d expected 1/%0d/77/%0d",
                               k, yes, rob_id, v1, v2, k, k + 100); end
         if (k == 0) begin
            checks++; if (full !== 1'b0) begin errors++; $display("FAIL fill_slot_free: got %0b expected 0", full); end
         end
      end
      tick();
      checks++; if (yes !== 1'b0 || full !== 1'b0) begin
         errors++; $display("FAIL fill_drained: got yes=%0b full=%0b expected 0/0", yes, full); end
   endtask

   task automatic test_flush();
      do_reset();
      for (int k = 0; k < 8; k++) begin
         set_dsp(11'h033, 1'b1, 4'(k % 3 + 1), 32'd0, 1'b0, 4'd0, 32'd3, 4'(k));
         tick(); idle();
      end
      checks++; if (full !== 1'b1) begin errors++; $display("FAIL flush_pre_full: got %0b expected 1", full); end
      clear_in = 1'b1;
      set_dsp(11'h033, 1'b0, 4'd0, 32'd1, 1'b0, 4'd0, 32'd2, 4'd12);
      tick(); idle();
      checks++; if (full !== 1'b0 || yes !== 1'b0) begin
         errors++; $display("FAIL flush_clear: got full=%0b yes=%0b expected 0/0", full, yes); end
      cdb0_valid = 1'b1; cdb0_rob_id = 4'd1; cdb0_value = 32'd11;
      cdb1_valid = 1'b1; cdb1_rob_id = 4'd2; cdb1_value = 32'd22;
      tick(); idle();
      cdb0_valid = 1'b1; cdb0_rob_id = 4'd3; cdb0_value = 32'd33;
      tick(); idle();
      for (int k = 0; k < 4; k++) begin
         tick();
         checks++; if (yes !== 1'b0) begin errors++; $display("FAIL flush_no_issue%0d: got %0b expected 0", k, yes); end
      end
   endtask

   task automatic test_async_reset();
      do_reset();
      set_dsp(11'h033, 1'b0, 4'd0, 32'h55, 1'b0, 4'd0, 32'h66, 4'd6);
      tick(); idle();
      tick();
      checks++; if (yes !== 1'b1) begin errors++; $display("FAIL areset_pre: got %0b expected 1", yes); end
      #2;
      rst_in = 1'b1;
      #1;
      checks++; if (yes !== 1'b0 || full !== 1'b0) begin
         errors++; $display("FAIL areset_now: got yes=%0b full=%0b expected 0/0", yes, full); end
      checks++; if ({op, v1, v2, pc, imm, is_short, rob_id} !== 144'd0) begin
         errors++; $display("FAIL areset_payload: got %h expected 0", {op, v1, v2, pc, imm, is_short, rob_id}); end
      #1;
      rst_in = 1'b0;
      model_reset();
      tick();
      checks++; if (yes !== 1'b0 || full !== 1'b0) begin
         errors++; $display("FAIL areset_empty: got yes=%0b full=%0b expected 0/0", yes, full); end
   endtask

   task automatic test_random();
      do_reset();
      for (int n = 0; n < 3000; n++) begin
         dsp_valid    = ($urandom_range(0, 9) < 6);
         dsp_op       = 11'($urandom);
         dsp_q1_busy  = 1'($urandom_range(0, 1));
         dsp_q2_busy  = 1'($urandom_range(0, 1));
         dsp_q1       = 4'($urandom);
         dsp_q2       = 4'($urandom);
         dsp_v1       = $urandom;
         dsp_v2       = $urandom;
         dsp_pc       = $urandom;
         dsp_imm      = $urandom;
         dsp_is_short = 1'($urandom_range(0, 1));
         dsp_rob_id   = 4'($urandom);
         cdb0_valid   = 1'($urandom_range(0, 1));
         cdb0_rob_id  = 4'($urandom);
         cdb0_value   = $urandom;
         cdb1_valid   = 1'($urandom_range(0, 1));
         cdb1_rob_id  = 4'($urandom);
         cdb1_value   = $urandom;
         if (cdb0_valid && cdb1_valid && cdb1_rob_id == cdb0_rob_id) cdb1_rob_id = cdb0_rob_id + 4'd1;
         clear_in     = ($urandom_range(0, 63) == 0);
         tick();
         checks++; if (yes !== m_yes) begin errors++; $display("FAIL rand_yes@%0d: got %0b expected %0b", n, yes, m_yes); end
         checks++; if (full !== m_full()) begin errors++; $display("FAIL rand_full@%0d: got %0b expected %0b", n, full, m_full()); end
         checks++; if ({op, v1, v2, pc, imm, is_short, rob_id} !== {m_op, m_v1, m_v2, m_pc, m_imm, m_sh, m_rob}) begin
            errors++; $display("FAIL rand_payload@%0d: got %h expected %h", n,
                               {op, v1, v2, pc, imm, is_short, rob_id}, {m_op, m_v1, m_v2, m_pc, m_imm, m_sh, m_rob}); end
      end
      idle();
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      idle();
      rst_in = 1'b1;
      model_reset();
      test_reset();
      test_ready_dispatch();
      test_pending();
      test_forward();
      test_fill_priority();
      test_flush();
      test_async_reset();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
